// File: rtl/channel_event_arbiter.sv
// Round-robin arbiter funnelling per-channel event words into one shared FIFO.
// A grant cycle is always followed by a HOLD cycle, so a requester has time to drop req.
module channel_event_arbiter #(
    parameter int NUMCHANNELS = 32,
    parameter int WIDTH       = 54,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUMCHANNELS-1:0]       channel_req,
    input  logic [NUMCHANNELS*WIDTH-1:0] channel_event,
    input  logic [NUMCHANNELS-1:0]       channel_mask,
    input  logic                         fifo_full,
    output logic [NUMCHANNELS-1:0]       channel_ack,
    output logic                         fifo_write,
    output logic [WIDTH-1:0]             fifo_data,
    output logic [CNT_W-1:0]             events_granted
);

    localparam int PTR_W = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1;
    localparam logic [PTR_W:0]   N_EXT = (PTR_W+1)'(NUMCHANNELS);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUMCHANNELS - 1);

    typedef enum logic {ST_ARB, ST_HOLD} state_t;

    state_t                  r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [NUMCHANNELS-1:0]  r_ack;
    logic                    r_write;
    logic [WIDTH-1:0]        r_data;
    logic [CNT_W-1:0]        r_cnt;

    logic [WIDTH-1:0]        w_words [NUMCHANNELS];
    logic [NUMCHANNELS-1:0]  w_eligible;
    logic [PTR_W:0]          w_idx;
    logic [PTR_W-1:0]        w_winner;
    logic [PTR_W-1:0]        w_ptr_next;
    logic                    w_found;
    logic                    w_grant;

    generate
        for (genvar gi = 0; gi < NUMCHANNELS; gi++) begin : g_words
            assign w_words[gi] = channel_event[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_eligible = channel_req & ~channel_mask;

    // Scan upward from r_ptr with wrap; the first eligible channel wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUMCHANNELS; k++) begin
            w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_idx >= N_EXT) begin
                w_idx = w_idx - N_EXT;
            end
            if (!w_found && w_eligible[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_ptr_next = (w_winner == LAST) ? '0 : w_winner + PTR_W'(1);
    assign w_grant    = w_found && !fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_ack   <= '0;
            r_write <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (w_grant) begin
                        r_ack   <= NUMCHANNELS'(1) << w_winner;
                        r_write <= 1'b1;
                        r_data  <= w_words[w_winner];
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: r_state <= ST_ARB;
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign channel_ack    = r_ack;
    assign fifo_write     = r_write;
    assign fifo_data      = r_data;
    assign events_granted = r_cnt;

endmodule

// File: tb/tb_channel_event_arbiter.sv
// Bench for channel_event_arbiter: vector table, directed corner sequences and a
// randomized run checked against a queue-free arithmetic model of the arbiter.
module tb_channel_event_arbiter;

    localparam int N  = 32;
    localparam int W  = 54;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     channel_req;
    logic [N*W-1:0]   channel_event;
    logic [N-1:0]     channel_mask;
    logic             fifo_full;
    logic [N-1:0]     channel_ack;
    logic             fifo_write;
    logic [W-1:0]     fifo_data;
    logic [CW-1:0]    events_granted;

    channel_event_arbiter #(.NUMCHANNELS(N), .WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .channel_req    (channel_req),
        .channel_event  (channel_event),
        .channel_mask   (channel_mask),
        .fifo_full      (fifo_full),
        .channel_ack    (channel_ack),
        .fifo_write     (fifo_write),
        .fifo_data      (fifo_data),
        .events_granted (events_granted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pointer, busy flag, counter, last written word.
    int            m_ptr;
    bit            m_hold;
    logic [CW-1:0] m_cnt;
    logic [W-1:0]  m_data;
    logic [N-1:0]  e_ack;
    logic          e_write;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] mask;
        bit           full;
        int           exp_ch;
    } vec_t;
    vec_t tab [14];

    function automatic logic [W-1:0] fixed_word(int i);
        return (W'(i) << 32) | W'(1);
    endfunction

    task automatic set_word(int ch, logic [W-1:0] w);
        channel_event[ch*W +: W] = w;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_hold = 0; m_cnt = '0; m_data = '0;
    endtask

    task automatic predict();
        logic [N-1:0] elig;
        int win;
        elig = channel_req & ~channel_mask;
        e_ack = '0;
        e_write = 1'b0;
        win = -1;
        if (!m_hold && !fifo_full && elig != '0) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            e_ack[win] = 1'b1;
            e_write    = 1'b1;
            m_data     = channel_event[win*W +: W];
            m_ptr      = (win + 1) % N;
            m_cnt      = m_cnt + 1'b1;
            m_hold     = 1'b1;
        end else begin
            m_hold = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] ea, input logic ew,
                         input logic [W-1:0] ed, input logic [CW-1:0] ec);
        total++;
        if (channel_ack !== ea || fifo_write !== ew || fifo_data !== ed || events_granted !== ec) begin
            bad++;
            $display("FAIL %s: got ack=%h write=%b data=%h cnt=%0d, expected ack=%h write=%b data=%h cnt=%0d",
                     name, channel_ack, fifo_write, fifo_data, events_granted, ea, ew, ed, ec);
        end
    endtask

    task automatic expect_ack(input string name, input int ch);
        logic [N-1:0] ea;
        ea = '0;
        if (ch >= 0) ea[ch] = 1'b1;
        total++;
        if (channel_ack !== ea) begin
            bad++;
            $display("FAIL %s: got ack=%h, expected ack=%h", name, channel_ack, ea);
        end
    endtask

    task automatic tick(input string name);
        predict();
        @(posedge clk);
        #1;
        check(name, e_ack, e_write, m_data, m_cnt);
        if (fifo_write) $display("txn %s ack=%h data=%h cnt=%0d", name, channel_ack, fifo_data, events_granted);
    endtask

    // Requesters drop req when acked and re-raise with a fresh word with probability pct.
    task automatic serve(input int pct);
        for (int ch = 0; ch < N; ch++) begin
            if (channel_ack[ch]) begin
                channel_req[ch] = 1'b0;
            end else if (!channel_req[ch] && $urandom_range(99) < pct) begin
                channel_req[ch] = 1'b1;
                set_word(ch, W'({$urandom, $urandom}));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        channel_req = '0;
        channel_mask = '0;
        fifo_full = 1'b0;
        model_reset();
        #1;
        check("reset_state", '0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        logic [N-1:0] t_ack;
        logic [W-1:0] t_data;
        logic [CW-1:0] t_cnt;

        tab[0]  = '{32'h0000_0001, 32'h0, 1'b0, 0};
        tab[1]  = '{32'h0000_0001, 32'h0, 1'b1, -1};
        tab[2]  = '{32'h0000_0001, 32'h1, 1'b0, -1};
        tab[3]  = '{32'h8000_0001, 32'h0, 1'b0, 31};
        tab[4]  = '{32'h8000_0001, 32'h0, 1'b0, 0};
        tab[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0};
        tab[6]  = '{32'h0000_0006, 32'h0, 1'b0, 1};
        tab[7]  = '{32'h0000_0006, 32'h0, 1'b0, 2};
        tab[8]  = '{32'h0000_0004, 32'h4, 1'b0, -1};
        tab[9]  = '{32'h0000_0008, 32'h0, 1'b0, 3};
        tab[10] = '{32'h0000_0000, 32'h0, 1'b0, -1};
        tab[11] = '{32'h0000_0010, 32'h0, 1'b1, -1};
        tab[12] = '{32'h0000_0010, 32'h0, 1'b0, 4};
        tab[13] = '{32'h0000_000F, 32'h0, 1'b0, 0};

        channel_event = '0;
        for (int i = 0; i < N; i++) set_word(i, fixed_word(i));
        do_reset();

        // Vector table: each entry is one arbitration cycle followed by a quiet cycle.
        t_data = '0;
        t_cnt  = '0;
        for (int v = 0; v < 14; v++) begin
            channel_req  = tab[v].req;
            channel_mask = tab[v].mask;
            fifo_full    = tab[v].full;
            predict();
            @(posedge clk);
            #1;
            t_ack = '0;
            if (tab[v].exp_ch >= 0) begin
                t_ack[tab[v].exp_ch] = 1'b1;
                t_data = fixed_word(tab[v].exp_ch);
                t_cnt  = t_cnt + 1'b1;
            end
            check($sformatf("vec%0d", v), t_ack, tab[v].exp_ch >= 0, t_data, t_cnt);
            $display("txn vec%0d req=%h mask=%h full=%b ack=%h write=%b", v, tab[v].req,
                     tab[v].mask, tab[v].full, channel_ack, fifo_write);
            channel_req = '0; channel_mask = '0; fifo_full = 1'b0;
            tick($sformatf("vec%0d_quiet", v));
        end

        // FIFO full stall keeps pointer; release grants lowest channel from ptr 0.
        do_reset();
        channel_req = 32'h0000_000A;
        fifo_full = 1'b1;
        for (int c = 0; c < 10; c++) tick("full_stall");
        fifo_full = 1'b0;
        tick("full_release");
        expect_ack("full_release_ch1", 1);
        serve(0);
        tick("full_hold");
        tick("full_next");
        expect_ack("full_next_ch3", 3);

        // Wrap from ptr=5: channel 31 then channel 0, then ptr=1.
        do_reset();
        channel_req = 32'h0000_0010;
        tick("ptr5_setup");
        serve(0);
        tick("ptr5_hold");
        channel_req = 32'h8000_0001;
        tick("wrap_31");
        expect_ack("wrap_first_ch31", 31);
        serve(0);
        tick("wrap_hold");
        tick("wrap_0");
        expect_ack("wrap_second_ch0", 0);
        serve(0);
        tick("wrap_hold2");
        channel_req = 32'h0000_0003;
        tick("ptr_after_wrap");
        expect_ack("ptr_is_1", 1);

        // Mask all but channel 0; clearing the mask in HOLD hands the next grant to channel 1.
        do_reset();
        channel_req = '1;
        channel_mask = 32'hFFFF_FFFE;
        for (int c = 0; c < 5; c++) begin
            tick("mask_only0");
            serve(100);
        end
        expect_ack("mask_hold_ch0", 0);
        channel_mask = '0;
        tick("mask_cleared_hold");
        serve(100);
        tick("mask_cleared_grant");
        expect_ack("mask_next_ch1", 1);

        // All channels requesting: strict 0..31,0 order, then counter wrap.
        do_reset();
        channel_req = '1;
        grants = 0;
        for (int c = 0; c < 66; c++) begin
            tick("all_req");
            if (fifo_write) begin
                expect_ack($sformatf("all_req_grant%0d", grants), grants % N);
                grants++;
            end
            serve(100);
        end
        total++;
        if (events_granted !== CW'(33)) begin
            bad++;
            $display("FAIL all_req_count: got %0d, expected 33", events_granted);
        end
        for (int c = 0; c < 448; c++) begin
            tick("cnt_wrap");
            serve(100);
        end
        total++;
        if (events_granted !== CW'(1)) begin
            bad++;
            $display("FAIL cnt_wrap: got %0d, expected 1", events_granted);
        end

        // Reset asserted in HOLD after granting channel 7.
        do_reset();
        set_word(7, fixed_word(7));
        channel_req = 32'h0000_0080;
        tick("pre_reset_grant7");
        expect_ack("grant_ch7", 7);
        serve(0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_in_hold", '0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        channel_req = 32'h0000_0204;
        tick("post_reset");
        expect_ack("post_reset_ch2", 2);
        serve(0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            fifo_full = ($urandom_range(99) < 25);
            if ($urandom_range(99) < 10) channel_mask = $urandom & $urandom;
            serve(30);
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
